// File: rtl/std_cache_pkg.sv
// Shared data-cache constants and the arbitration-mode type.
package std_cache_pkg;

    localparam int unsigned DcacheIndexWidth = 12;
    localparam int unsigned DcacheTagWidth   = 44;
    localparam int unsigned DcacheLineWidth  = 128;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Map an integer enable parameter onto the arbitration mode.
    function automatic arb_mode_e arb_mode(input int unsigned rr_enable);
        return (rr_enable != 0) ? ARB_RR : ARB_FIXED;
    endfunction

endpackage

// File: rtl/dcache_rr_pick.sv
// Rotating picker: first requesting port at or after ptr_i, searching
// ports 1..NumPorts-1 and wrapping from NumPorts-1 back to 1.
// Bit 0 of req_i is ignored by construction (never reached by the search
// when ptr_i >= 1).
module dcache_rr_pick #(
    parameter int unsigned NumPorts = 5
) (
    input  logic [NumPorts-1:0]         req_i,
    input  logic [$clog2(NumPorts)-1:0] ptr_i,
    output logic [NumPorts-1:0]         gnt_o
);

    localparam int unsigned IdW = $clog2(NumPorts);

    // Walk NumPorts-1 candidates starting at the pointer; first hit wins.
    always_comb begin
        int unsigned      v_pos;
        logic [IdW-1:0]   v_sel;
        logic             v_found;
        gnt_o   = '0;
        v_found = 1'b0;
        v_pos   = 0;
        v_sel   = '0;
        for (int unsigned k = 0; k < NumPorts - 1; k++) begin
            v_pos = 32'(ptr_i) + k;
            if (v_pos >= NumPorts) begin
                v_pos = v_pos - (NumPorts - 1);
            end
            v_sel = IdW'(v_pos);
            if (!v_found && req_i[v_sel]) begin
                gnt_o[v_sel] = 1'b1;
                v_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_sram_arbiter.sv
// Data-cache SRAM arbiter: grants one of NumPorts requestors per cycle
// (port 0 = miss handler, highest priority), forwards its command to the
// tag/data SRAMs and returns read valid plus per-way hit one cycle later.
// Optional starvation escalation is compiled in with DCACHE_ARB_STARVE_EN.
module dcache_sram_arbiter
    import std_cache_pkg::*;
#(
    parameter int unsigned NumPorts    = 5,
    parameter int unsigned SetAssoc    = 8,
    parameter int unsigned IndexWidth  = DcacheIndexWidth,
    parameter int unsigned TagWidth    = DcacheTagWidth,
    parameter int unsigned LineWidth   = DcacheLineWidth,
    parameter int unsigned RrEnable    = 1,
    parameter int unsigned StarveLimit = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumPorts*SetAssoc-1:0]     req_i,
    input  logic [NumPorts*IndexWidth-1:0]   addr_i,
    input  logic [NumPorts-1:0]              we_i,
    input  logic [NumPorts*LineWidth-1:0]    wdata_i,
    input  logic [NumPorts*LineWidth/8-1:0]  be_i,
    input  logic [NumPorts*TagWidth-1:0]     tag_i,
    output logic [NumPorts-1:0]              gnt_o,
    output logic [NumPorts-1:0]              rvalid_o,
    output logic [SetAssoc*LineWidth-1:0]    rdata_o,
    output logic [SetAssoc-1:0]              hit_way_o,
    output logic [SetAssoc-1:0]              req_ram_o,
    output logic [IndexWidth-1:0]            addr_ram_o,
    output logic                             we_ram_o,
    output logic [LineWidth-1:0]             wdata_ram_o,
    output logic [LineWidth/8-1:0]           be_ram_o,
    input  logic [SetAssoc*LineWidth-1:0]    ram_rdata_i,
    input  logic [SetAssoc*TagWidth-1:0]     ram_rtag_i,
    input  logic [SetAssoc-1:0]              ram_valid_i
);

    localparam int unsigned IdW     = $clog2(NumPorts);
    localparam int unsigned BeWidth = LineWidth / 8;
    localparam arb_mode_e   ArbMode = arb_mode(RrEnable);

    // Elaboration-time parameter sanity.
    if (NumPorts < 2 || StarveLimit == 0) begin : g_bad_param
        $error("dcache_sram_arbiter: NumPorts must be >= 2 and StarveLimit >= 1");
    end

    logic [NumPorts-1:0] w_req;
    logic [NumPorts-1:0] w_rr_req;
    logic [NumPorts-1:0] w_rr_gnt;
    logic [NumPorts-1:0] w_starve;
    logic [NumPorts-1:0] w_gnt;
    logic [IdW-1:0]      w_pick_ptr;
    logic [IdW-1:0]      w_win_id;
    logic                w_any_gnt;
    logic                w_resp;
    logic [TagWidth-1:0] w_tag_q;

    logic [IdW-1:0]      r_rr_ptr;
    logic [IdW-1:0]      r_id_q;
    logic                r_id_vld_q;
    logic                r_we_q;

    // A port requests when any of its way-select bits is set.
    always_comb begin
        w_req = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            w_req[p] = |req_i[p*SetAssoc +: SetAssoc];
        end
    end

    // Picker sees ports 1..N-1 only; fixed priority is a pinned pointer of 1.
    always_comb begin
        w_rr_req    = w_req;
        w_rr_req[0] = 1'b0;
        w_pick_ptr  = (ArbMode == ARB_RR) ? r_rr_ptr : IdW'(1);
    end

    dcache_rr_pick #(
        .NumPorts (NumPorts)
    ) u_rr_pick (
        .req_i (w_rr_req),
        .ptr_i (w_pick_ptr),
        .gnt_o (w_rr_gnt)
    );

`ifdef DCACHE_ARB_STARVE_EN
    localparam int unsigned CntW = $clog2(StarveLimit + 1);

    logic [CntW-1:0] r_wait_q [NumPorts];

    // Saturating wait counters: count blocked cycles, clear on grant or drop.
    always_ff @(posedge clk_i) begin
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (!rst_ni) begin
                r_wait_q[p] <= '0;
            end else if (!w_req[p] || w_gnt[p]) begin
                r_wait_q[p] <= '0;
            end else if (r_wait_q[p] < CntW'(StarveLimit)) begin
                r_wait_q[p] <= r_wait_q[p] + CntW'(1);
            end
        end
    end

    // A starved port must still be requesting this cycle to be escalated.
    always_comb begin
        w_starve = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            w_starve[p] = w_req[p] && (r_wait_q[p] >= CntW'(StarveLimit));
        end
    end
`else
    assign w_starve = '0;
`endif

    // Grant: starved (lowest index) > port 0 > picker; masked during reset.
    always_comb begin
        logic v_found;
        w_gnt   = '0;
        v_found = 1'b0;
        if (rst_ni) begin
            for (int unsigned p = 0; p < NumPorts; p++) begin
                if (!v_found && w_starve[p]) begin
                    w_gnt[p] = 1'b1;
                    v_found  = 1'b1;
                end
            end
            if (!v_found) begin
                if (w_req[0]) begin
                    w_gnt[0] = 1'b1;
                end else begin
                    w_gnt = w_rr_gnt;
                end
            end
        end
    end

    assign gnt_o     = w_gnt;
    assign w_any_gnt = |w_gnt;

    // Steer the winner's command onto the SRAM; all-zero when idle.
    always_comb begin
        w_win_id    = '0;
        req_ram_o   = '0;
        addr_ram_o  = '0;
        we_ram_o    = 1'b0;
        wdata_ram_o = '0;
        be_ram_o    = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (w_gnt[p]) begin
                w_win_id    = IdW'(p);
                req_ram_o   = req_i[p*SetAssoc +: SetAssoc];
                addr_ram_o  = addr_i[p*IndexWidth +: IndexWidth];
                we_ram_o    = we_i[p];
                wdata_ram_o = wdata_i[p*LineWidth +: LineWidth];
                be_ram_o    = be_i[p*BeWidth +: BeWidth];
            end
        end
    end

    // Round-robin pointer advances past a granted non-miss port.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rr_ptr <= IdW'(1);
        end else if (w_any_gnt && !w_gnt[0]) begin
            r_rr_ptr <= (w_win_id == IdW'(NumPorts - 1)) ? IdW'(1) : w_win_id + IdW'(1);
        end
    end

    // Remember who was granted and whether it wrote, for the response cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_id_vld_q <= 1'b0;
            r_id_q     <= '0;
            r_we_q     <= 1'b0;
        end else begin
            r_id_vld_q <= w_any_gnt;
            r_id_q     <= w_win_id;
            r_we_q     <= we_ram_o;
        end
    end

    assign w_resp = r_id_vld_q && !r_we_q;

    // Read response valid for the registered winner.
    always_comb begin
        rvalid_o = '0;
        if (w_resp) begin
            rvalid_o[r_id_q] = 1'b1;
        end
    end

    // Compare tag of the port being answered.
    always_comb begin
        w_tag_q = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            if (r_id_q == IdW'(p)) begin
                w_tag_q = tag_i[p*TagWidth +: TagWidth];
            end
        end
    end

    // Per-way hit, only in a read response cycle.
    always_comb begin
        hit_way_o = '0;
        for (int unsigned w = 0; w < SetAssoc; w++) begin
            hit_way_o[w] = w_resp && ram_valid_i[w] &&
                           (ram_rtag_i[w*TagWidth +: TagWidth] == w_tag_q);
        end
    end

    assign rdata_o = ram_rdata_i;

`ifndef SYNTHESIS
    a_hit_onehot : assert property (@(posedge clk_i) $onehot0(hit_way_o))
        else $error("dcache_sram_arbiter: multiple ways hit");
`endif

endmodule
